mac_seq: RTL and testbench

Initiator-side sequencer for the `mac` block. It holds a small table of B/C operand pairs, issues them to `mac` one at a time using the Load/Done handshake, and feeds each returned Aout back as the next Ain. After the programmed number of pairs it presents the final accumulated value. Operand data is opaque 8-bit; this block performs no arithmetic on it.

---
 rtl/mac_seq_if.sv | 47 ++++
 rtl/mac_seq.sv | 178 +++++++++++++++++
 tb/tb_mac_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_if
//  Brief    : Bundle of host-side table/run control and the mac Load/Done
//             handshake used by the mac_seq sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_seq_if;

  // host side: operand table writes and run control
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_b;
  logic [7:0] wr_c;
  logic       start;
  logic [3:0] count;
  logic       busy;
  logic       finished;
  logic       error;
  logic [7:0] result;

  // mac side: operand issue and completion
  logic [7:0] mac_ain;
  logic [7:0] mac_b;
  logic [7:0] mac_c;
  logic       mac_load;
  logic       mac_done;
  logic [7:0] mac_aout;

  // environment view: drives the host controls and plays the mac role
  modport master (
    output wr_en, wr_addr, wr_b, wr_c, start, count,
    input  busy, finished, error, result,
    input  mac_ain, mac_b, mac_c, mac_load,
    output mac_done, mac_aout
  );

  // sequencer view
  modport slave (
    input  wr_en, wr_addr, wr_b, wr_c, start, count,
    output busy, finished, error, result,
    output mac_ain, mac_b, mac_c, mac_load,
    input  mac_done, mac_aout
  );

endinterface
`default_nettype wire

// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq
//  Brief    : Initiator-side sequencer for the mac block. Holds a table of
//             B/C operand pairs, issues them one at a time over Load/Done,
//             chains each returned Aout into the next Ain and reports the
//             final accumulated value. Operand data is passed through
//             untouched; no arithmetic is done here.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_seq #(
  parameter int         DEPTH   = 8,
  parameter logic [7:0] A_INIT  = 8'h00,
  parameter int         TIMEOUT = 255
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mac_seq_if.slave   bus
);

  localparam logic [3:0] c_DEPTH   = 4'(DEPTH);
  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_timer;
  logic [7:0] r_acc;

  // The table is always eight entries deep so the 3-bit address can index
  // it directly; entries at or above DEPTH are simply never written.
  logic [7:0] r_tab_b [0:7];
  logic [7:0] r_tab_c [0:7];

  logic       r_busy;
  logic       r_finished;
  logic       r_error;
  logic [7:0] r_result;
  logic [7:0] r_mac_ain;
  logic [7:0] r_mac_b;
  logic [7:0] r_mac_c;
  logic       r_mac_load;

  logic [3:0] w_cnt_clamp;
  logic       w_wr_ok;
  logic [2:0] w_idx_nxt;
  logic       w_last;
  logic       w_timeout;

  // Run length clamp, write qualification and per-pair progress terms.
  always_comb begin
    w_cnt_clamp = (bus.count > c_DEPTH) ? c_DEPTH : bus.count;
    w_wr_ok     = bus.wr_en && !r_busy && ({1'b0, bus.wr_addr} < c_DEPTH);
    w_idx_nxt   = r_idx + 3'd1;
    w_last      = (({1'b0, r_idx} + 4'd1) == r_cnt);
    w_timeout   = ((r_timer + 8'd1) == c_TIMEOUT);
  end

  // Sequencer state machine; every output is registered and updated on the
  // transition into the state that presents it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_cnt      <= 4'd0;
      r_timer    <= 8'd0;
      r_acc      <= A_INIT;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_error    <= 1'b0;
      r_result   <= 8'd0;
      r_mac_ain  <= 8'd0;
      r_mac_b    <= 8'd0;
      r_mac_c    <= 8'd0;
      r_mac_load <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_tab_b[i] <= 8'd0;
        r_tab_c[i] <= 8'd0;
      end
    end else begin
      // Writes are blocked while busy so the operands of a run stay fixed.
      if (w_wr_ok) begin
        r_tab_b[bus.wr_addr] <= bus.wr_b;
        r_tab_c[bus.wr_addr] <= bus.wr_c;
      end

      // Pulse outputs default low.
      r_finished <= 1'b0;
      r_mac_load <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_error <= 1'b0;
            if (bus.count != 4'd0) begin
              r_cnt      <= w_cnt_clamp;
              r_idx      <= 3'd0;
              r_acc      <= A_INIT;
              r_busy     <= 1'b1;
              r_mac_load <= 1'b1;
              r_mac_ain  <= A_INIT;
              r_mac_b    <= r_tab_b[0];
              r_mac_c    <= r_tab_c[0];
              r_state    <= S_ISSUE;
            end else begin
              // Empty run: report the initial accumulator immediately.
              r_result   <= A_INIT;
              r_finished <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end

        S_ISSUE: begin
          // Any Done seen here belongs to an earlier transaction; ignore it.
          r_timer <= 8'd0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.mac_done) begin
            // Done takes priority over a coincident timeout.
            r_acc <= bus.mac_aout;
            r_idx <= w_idx_nxt;
            if (w_last) begin
              r_result   <= bus.mac_aout;
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_mac_load <= 1'b1;
              r_mac_ain  <= bus.mac_aout;
              r_mac_b    <= r_tab_b[w_idx_nxt];
              r_mac_c    <= r_tab_c[w_idx_nxt];
              r_state    <= S_ISSUE;
            end
          end else if (w_timeout) begin
            // Abort: report what was accumulated before the stuck pair.
            r_error    <= 1'b1;
            r_result   <= r_acc;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.finished = r_finished;
  assign bus.error    = r_error;
  assign bus.result   = r_result;
  assign bus.mac_ain  = r_mac_ain;
  assign bus.mac_b    = r_mac_b;
  assign bus.mac_c    = r_mac_c;
  assign bus.mac_load = r_mac_load;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_seq
//  Brief    : Directed self-checking bench for mac_seq with a behavioural
//             mac model (Aout = Ain + B*C mod 256, configurable latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

  logic clk;
  logic rst;
  int   cyc;

  mac_seq_if ifc ();

  mac_seq #(
    .DEPTH  (8),
    .A_INIT (8'h00),
    .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mac model controls: 0 = normal, 1 = never Done, 2 = stale Done at Load
  int mode;
  int lat;

  // monitor / model state
  int         n_load_tot;
  int         n_fin_tot;
  int         load_cyc [0:63];
  logic [7:0] load_b   [0:63];
  logic [7:0] load_c   [0:63];
  logic       pending;
  int         since;
  logic [7:0] m_ain, m_b, m_c;
  logic [15:0] m_sum;

  int n_chk;
  int n_pass;

  // Cycle counter, mac model and Load/Finished monitor, sampled 1 after edge.
  initial begin
    cyc = 0; n_load_tot = 0; n_fin_tot = 0; pending = 1'b0; since = 0;
    m_ain = 8'd0; m_b = 8'd0; m_c = 8'd0; m_sum = 16'd0;
    ifc.mac_done = 1'b0; ifc.mac_aout = 8'd0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      ifc.mac_done = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (ifc.finished) n_fin_tot++;
        if (ifc.mac_load) begin
          load_cyc[n_load_tot % 64] = cyc;
          load_b[n_load_tot % 64]   = ifc.mac_b;
          load_c[n_load_tot % 64]   = ifc.mac_c;
          n_load_tot++;
          m_ain = ifc.mac_ain; m_b = ifc.mac_b; m_c = ifc.mac_c;
          pending = 1'b1;
          since = 0;
          if (mode == 2) begin
            ifc.mac_done = 1'b1;
            ifc.mac_aout = 8'hEE;
          end
        end else if (pending) begin
          since++;
          if (since == lat && mode != 1) begin
            m_sum = {8'd0, m_ain} + ({8'd0, m_b} * {8'd0, m_c});
            ifc.mac_done = 1'b1;
            ifc.mac_aout = m_sum[7:0];
            pending = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] b, input logic [7:0] c);
    ifc.wr_en = 1'b1; ifc.wr_addr = a; ifc.wr_b = b; ifc.wr_c = c;
    step();
    ifc.wr_en = 1'b0;
  endtask

  int s_cyc, fin_cyc, base_load, base_fin;

  task automatic start_run(input logic [3:0] n);
    base_load = n_load_tot;
    base_fin  = n_fin_tot;
    s_cyc     = cyc;
    ifc.start = 1'b1;
    ifc.count = n;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_fin();
    bit found;
    found = 1'b0;
    fin_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (ifc.finished) begin
        found = 1'b1;
        fin_cyc = cyc;
        break;
      end
      step();
    end
    chk("fin_seen", 32'(found), 32'd1);
  endtask

  task automatic load_basic();
    wr(3'd0, 8'd1, 8'd4);
    wr(3'd1, 8'd2, 8'd5);
    wr(3'd2, 8'd3, 8'd6);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    mode = 0; lat = 3;
    rst = 1'b1;
    ifc.wr_en = 1'b0; ifc.wr_addr = 3'd0; ifc.wr_b = 8'd0; ifc.wr_c = 8'd0;
    ifc.start = 1'b0; ifc.count = 4'd0;
    repeat (3) step();
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_load", 32'(ifc.mac_load), 0);
    chk("rst_result", 32'(ifc.result), 0);
    chk("rst_error", 32'(ifc.error), 0);
    rst = 1'b0;
    step();

    // Basic run, with a dropped write to entry 0 while busy.
    load_basic();
    start_run(4'd3);
    chk("basic_busy", 32'(ifc.busy), 1);
    step();
    wr(3'd0, 8'h99, 8'h99);
    wait_fin();
    chk("basic_nload", 32'(n_load_tot - base_load), 3);
    chk("basic_load0", 32'(load_cyc[base_load % 64] - s_cyc), 1);
    chk("basic_load1", 32'(load_cyc[(base_load + 1) % 64] - s_cyc), 5);
    chk("basic_load2", 32'(load_cyc[(base_load + 2) % 64] - s_cyc), 9);
    chk("basic_fin", 32'(fin_cyc - s_cyc), 13);
    chk("basic_result", 32'(ifc.result), 32'h20);
    chk("basic_error", 32'(ifc.error), 0);
    step();
    chk("basic_finished_once", 32'(n_fin_tot - base_fin), 1);

    // Single pair: entry 0 must still hold 1/4.
    start_run(4'd1);
    wait_fin();
    chk("busywr_b", 32'(load_b[base_load % 64]), 1);
    chk("busywr_c", 32'(load_c[base_load % 64]), 4);
    chk("one_result", 32'(ifc.result), 4);
    step();

    // Timeout: mac never answers.
    mode = 1;
    start_run(4'd2);
    wait_fin();
    chk("to_nload", 32'(n_load_tot - base_load), 1);
    chk("to_fin", 32'(fin_cyc - s_cyc), 12);
    chk("to_error", 32'(ifc.error), 1);
    chk("to_result", 32'(ifc.result), 0);
    step();
    chk("to_error_hold", 32'(ifc.error), 1);
    mode = 0;

    // Count = 0 clears Error, no Load.
    start_run(4'd0);
    wait_fin();
    chk("c0_fin", 32'(fin_cyc - s_cyc), 1);
    chk("c0_nload", 32'(n_load_tot - base_load), 0);
    chk("c0_result", 32'(ifc.result), 0);
    chk("c0_error", 32'(ifc.error), 0);
    step();

    // Stale Done at Load, real Done at latency 2.
    mode = 2; lat = 2;
    start_run(4'd2);
    wait_fin();
    chk("stale_nload", 32'(n_load_tot - base_load), 2);
    chk("stale_fin", 32'(fin_cyc - s_cyc), 7);
    chk("stale_result", 32'(ifc.result), 32'h0E);
    step();
    mode = 0; lat = 3;

    // Wrap and clamp: 8 x (16*16) = 2048 -> 0 mod 256.
    for (int i = 0; i < 8; i++) wr(3'(i), 8'd16, 8'd16);
    start_run(4'd15);
    wait_fin();
    chk("wrap_fin", 32'(fin_cyc - s_cyc), 33);
    chk("wrap_result", 32'(ifc.result), 0);
    repeat (3) step();
    chk("wrap_nload", 32'(n_load_tot - base_load), 8);
    chk("wrap_finished_once", 32'(n_fin_tot - base_fin), 1);

    // Basic again to get a nonzero Result ahead of the reset test.
    load_basic();
    start_run(4'd3);
    wait_fin();
    chk("basic2_result", 32'(ifc.result), 32'h20);
    step();

    // Reset during WAIT of the second pair.
    start_run(4'd3);
    for (int i = 0; i < 50; i++) begin
      if (n_load_tot - base_load >= 2) break;
      step();
    end
    chk("mid_load2", 32'(n_load_tot - base_load), 2);
    step();
    chk("mid_ain_pre", 32'(ifc.mac_ain), 4);
    rst = 1'b1;
    step();
    chk("mid_busy", 32'(ifc.busy), 0);
    chk("mid_load", 32'(ifc.mac_load), 0);
    chk("mid_fin", 32'(ifc.finished), 0);
    chk("mid_result", 32'(ifc.result), 0);
    chk("mid_ain", 32'(ifc.mac_ain), 0);
    chk("mid_b", 32'(ifc.mac_b), 0);
    chk("mid_c", 32'(ifc.mac_c), 0);
    rst = 1'b0;
    repeat (20) step();
    chk("mid_no_fin", 32'(n_fin_tot - base_fin), 0);

    // Table cleared by reset.
    start_run(4'd2);
    wait_fin();
    chk("clr_ops", 32'(load_b[base_load % 64] | load_c[base_load % 64] |
                       load_b[(base_load + 1) % 64] | load_c[(base_load + 1) % 64]), 0);
    step();

    // Post-reset run matches the basic run.
    load_basic();
    start_run(4'd3);
    wait_fin();
    chk("post_fin", 32'(fin_cyc - s_cyc), 13);
    chk("post_result", 32'(ifc.result), 32'h20);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
